// File: rtl/lfsr_burst_ctrl.sv
// Burst sequencer for an external LFSR: takes seed+count commands, loads the seed,
// then streams LFSR states as a valid/ready burst with last/done/abort signalling.
module lfsr_burst_ctrl #(
   parameter int unsigned           NUM_BITS     = 8,
   parameter int unsigned           CNT_W        = 16,
   parameter logic [NUM_BITS-1:0]   DEFAULT_SEED = NUM_BITS'(1)
) (
   input  logic                i_Clk,
   input  logic                i_Rst_L,
   input  logic                i_Cmd_Valid,
   output logic                o_Cmd_Ready,
   input  logic [NUM_BITS-1:0] i_Cmd_Seed,
   input  logic [CNT_W-1:0]    i_Cmd_Count,
   input  logic                i_Abort,
   output logic                o_Lfsr_Enable,
   output logic                o_Lfsr_Seed_DV,
   output logic [NUM_BITS-1:0] o_Lfsr_Seed,
   input  logic [NUM_BITS-1:0] i_Lfsr_Data,
   output logic                o_Out_Valid,
   input  logic                i_Out_Ready,
   output logic [NUM_BITS-1:0] o_Out_Data,
   output logic                o_Out_Last,
   output logic                o_Burst_Done,
   output logic                o_Aborted,
   output logic                o_Period_Hit
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   logic [1:0]          state_q;
   logic [1:0]          state_d;
   logic [NUM_BITS-1:0] seed_q;
   logic [CNT_W-1:0]    remain_q;
   logic                first_q;
   logic                done_q;
   logic                aborted_q;
   logic                period_hit_q;

   logic accept;
   logic abort;
   logic run_act;
   logic last;
   logic handshake;

   // Handshake decode and next-state logic; abort suppresses the output handshake.
   always_comb begin
      accept    = i_Cmd_Valid & (state_q == ST_IDLE);
      abort     = i_Abort & (state_q != ST_IDLE);
      run_act   = (state_q == ST_RUN) & ~i_Abort;
      last      = run_act & (remain_q == CNT_W'(1));
      handshake = run_act & i_Out_Ready;
      state_d   = state_q;
      case (state_q)
         ST_IDLE: if (accept && (i_Cmd_Count != '0)) state_d = ST_LOAD;
         ST_LOAD: state_d = abort ? ST_IDLE : ST_RUN;
         ST_RUN:  if (abort || (handshake && last)) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Burst bookkeeping: latched seed, remaining words, status pulses and sticky period flag.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         seed_q       <= '0;
         remain_q     <= '0;
         first_q      <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         period_hit_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         if (accept) begin
            seed_q       <= (i_Cmd_Seed == '0) ? DEFAULT_SEED : i_Cmd_Seed;
            remain_q     <= i_Cmd_Count;
            first_q      <= 1'b1;
            period_hit_q <= 1'b0;
            done_q       <= (i_Cmd_Count == '0);
         end
         if (abort) begin
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
         end
         if (handshake) begin
            remain_q <= remain_q - CNT_W'(1);
            first_q  <= 1'b0;
            if (!first_q && (i_Lfsr_Data == seed_q)) period_hit_q <= 1'b1;
            if (last) done_q <= 1'b1;
         end
      end
   end

   assign o_Cmd_Ready    = (state_q == ST_IDLE);
   assign o_Lfsr_Seed_DV = (state_q == ST_LOAD) & ~i_Abort;
   assign o_Lfsr_Seed    = seed_q;
   assign o_Lfsr_Enable  = handshake & ~last;
   assign o_Out_Valid    = run_act;
   assign o_Out_Data     = run_act ? i_Lfsr_Data : '0;
   assign o_Out_Last     = last;
   assign o_Burst_Done   = done_q;
   assign o_Aborted      = aborted_q;
   assign o_Period_Hit   = period_hit_q;

endmodule
